uart_mmio_fifo: RTL and testbench

//  Buffered memory-mapped bridge between the CPU's memory stage and the UART.

---
 rtl/uart_mmio_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART bridge: CPU load/store decode in the 0x8xxx_xxxx region,
// with byte-wide RX and TX circular FIFOs between the CPU and the serial link.
module uart_mmio_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // FIFO storage is not reset; the pointers and counts define its contents.
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d;
    logic [DEPTH_LOG2-1:0] tx_rptr_q, tx_rptr_d;
    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d;
    logic [DEPTH_LOG2-1:0] rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]         tx_cnt_q,  tx_cnt_d;
    logic [CW-1:0]         rx_cnt_q,  rx_cnt_d;
    logic                  tx_drop_q, tx_drop_d;
    logic [31:0]           rdata_q,   rdata_d;

    logic        region_hit_s;
    logic        rd_acc_s;
    logic        wr_acc_s;
    logic [1:0]  reg_sel_s;
    logic        tx_full_s;
    logic        tx_empty_s;
    logic        rx_full_s;
    logic        rx_empty_s;
    logic        tx_push_s;
    logic        tx_pop_s;
    logic        rx_push_s;
    logic        rx_pop_s;
    logic        tx_drop_set_s;
    logic        tx_drop_clr_s;
    logic [7:0]  tx_cnt8_s;
    logic [7:0]  rx_cnt8_s;
    logic [31:0] rd_word_s;

    // Access decode and FIFO handshakes; flags come from the registered counts only.
    always_comb begin
        region_hit_s  = (addr[31:28] == 4'h8);
        rd_acc_s      = rd_en & ~stall & region_hit_s;
        wr_acc_s      = wr_en & ~stall & region_hit_s;
        reg_sel_s     = addr[3:2];

        tx_full_s     = (tx_cnt_q == CNT_FULL);
        tx_empty_s    = (tx_cnt_q == CNT_ZERO);
        rx_full_s     = (rx_cnt_q == CNT_FULL);
        rx_empty_s    = (rx_cnt_q == CNT_ZERO);

        tx_push_s     = wr_acc_s & (reg_sel_s == REG_TXDATA) & ~tx_full_s;
        tx_drop_set_s = wr_acc_s & (reg_sel_s == REG_TXDATA) & tx_full_s;
        tx_drop_clr_s = wr_acc_s & (reg_sel_s == REG_STATUS);
        tx_pop_s      = ~tx_empty_s & uart_din_ready;

        rx_push_s     = uart_dout_valid & ~rx_full_s;
        rx_pop_s      = rd_acc_s & (reg_sel_s == REG_RXDATA) & ~rx_empty_s;
    end

    // TX pointer and occupancy next state.
    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push_s) begin
            tx_wptr_d = tx_wptr_q + PTR_ONE;
        end else begin
            tx_wptr_d = tx_wptr_q;
        end
        if (tx_pop_s) begin
            tx_rptr_d = tx_rptr_q + PTR_ONE;
        end else begin
            tx_rptr_d = tx_rptr_q;
        end
        if (tx_push_s && !tx_pop_s) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end else if (!tx_push_s && tx_pop_s) begin
            tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
            tx_cnt_d = tx_cnt_q;
        end
    end

    // RX pointer and occupancy next state.
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push_s) begin
            rx_wptr_d = rx_wptr_q + PTR_ONE;
        end else begin
            rx_wptr_d = rx_wptr_q;
        end
        if (rx_pop_s) begin
            rx_rptr_d = rx_rptr_q + PTR_ONE;
        end else begin
            rx_rptr_d = rx_rptr_q;
        end
        if (rx_push_s && !rx_pop_s) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else if (!rx_push_s && rx_pop_s) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else begin
            rx_cnt_d = rx_cnt_q;
        end
    end

    // Sticky drop flag: a STATUS write and a TXDATA write can never coincide.
    always_comb begin
        tx_drop_d = tx_drop_q;
        if (tx_drop_set_s) begin
            tx_drop_d = 1'b1;
        end else if (tx_drop_clr_s) begin
            tx_drop_d = 1'b0;
        end else begin
            tx_drop_d = tx_drop_q;
        end
    end

    // Zero-extend the occupancy counts into byte fields for the COUNT register.
    always_comb begin
        tx_cnt8_s         = 8'h00;
        rx_cnt8_s         = 8'h00;
        tx_cnt8_s[CW-1:0] = tx_cnt_q;
        rx_cnt8_s[CW-1:0] = rx_cnt_q;
    end

    // Register read mux; rdata only moves on an accepted read.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_STATUS: rd_word_s = {29'h0000_0000, tx_drop_q, ~rx_empty_s, ~tx_full_s};
            REG_RXDATA: begin
                if (rx_empty_s) begin
                    rd_word_s = 32'h0000_0000;
                end else begin
                    rd_word_s = {24'h00_0000, rx_mem_q[rx_rptr_q]};
                end
            end
            REG_TXDATA: rd_word_s = 32'h0000_0000;
            REG_COUNT:  rd_word_s = {16'h0000, rx_cnt8_s, tx_cnt8_s};
            default:    rd_word_s = 32'h0000_0000;
        endcase
        if (rd_acc_s) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wptr_q <= PTR_ZERO;
            tx_rptr_q <= PTR_ZERO;
            rx_wptr_q <= PTR_ZERO;
            rx_rptr_q <= PTR_ZERO;
            tx_cnt_q  <= CNT_ZERO;
            rx_cnt_q  <= CNT_ZERO;
            tx_drop_q <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_drop_q <= tx_drop_d;
            rdata_q   <= rdata_d;
        end
    end

    // TX storage write port.
    always_ff @(posedge clk) begin
        if (rst_n && tx_push_s) begin
            tx_mem_q[tx_wptr_q] <= wdata;
        end
    end

    // RX storage write port.
    always_ff @(posedge clk) begin
        if (rst_n && rx_push_s) begin
            rx_mem_q[rx_wptr_q] <= uart_dout;
        end
    end

    assign rdata           = rdata_q;
    assign uart_din        = tx_mem_q[tx_rptr_q];
    assign uart_din_valid  = ~tx_empty_s;
    assign uart_dout_ready = ~rx_full_s;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed self-checking bench for uart_mmio_fifo: register map, FIFO
// ordering, full/empty boundaries, stall, wrap and mid-operation reset.
module tb_uart_mmio_fifo;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_COUNT  = 32'h8000_000C;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready;
    logic [7:0]  uart_dout;
    logic        uart_dout_valid;
    logic        uart_dout_ready;

    int chk_cnt;
    int pass_cnt;

    uart_mmio_fifo #(.DEPTH_LOG2(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .addr            (addr),
        .wdata           (wdata),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .rdata           (rdata),
        .uart_din        (uart_din),
        .uart_din_valid  (uart_din_valid),
        .uart_din_ready  (uart_din_ready),
        .uart_dout       (uart_dout),
        .uart_dout_valid (uart_dout_valid),
        .uart_dout_ready (uart_dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt = chk_cnt + 1;
        if (obs === exp_v) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [31:0] a);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        chk_cnt         = 0;
        pass_cnt        = 0;
        rst_n           = 1'b0;
        stall           = 1'b0;
        addr            = 32'h0000_0000;
        wdata           = 8'h00;
        rd_en           = 1'b0;
        wr_en           = 1'b0;
        uart_din_ready  = 1'b0;
        uart_dout       = 8'h55;
        uart_dout_valid = 1'b1;

        // Reset held two cycles with the receiver offering a byte.
        tick();
        tick();
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_din_valid", {31'h0, uart_din_valid}, 32'h0);
        check_val("rst_dout_ready", {31'h0, uart_dout_ready}, 32'h1);
        rst_n           = 1'b1;
        uart_dout_valid = 1'b0;
        cpu_read(A_COUNT);
        check_val("rst_count", rdata, 32'h0);
        cpu_read(A_STATUS);
        check_val("rst_status", rdata, 32'h1);

        // TX burst of nine bytes into an eight-deep FIFO with the transmitter stalled.
        for (int i = 0; i < 9; i++) begin
            cpu_write(A_TXDATA, 8'h41 + 8'(i));
            if (i == 0) begin
                check_val("tx_first_valid", {31'h0, uart_din_valid}, 32'h1);
            end
        end
        cpu_read(A_COUNT);
        check_val("tx_count_full", rdata, 32'h0000_0008);
        cpu_read(A_STATUS);
        check_val("tx_status_drop", rdata, 32'h4);
        cpu_read(32'h0000_0000);
        check_val("nonregion_hold", rdata, 32'h4);
        cpu_read(32'h8000_000F);
        check_val("alias_count", rdata, 32'h0000_0008);
        uart_din_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val("tx_drain_valid", {31'h0, uart_din_valid}, 32'h1);
            check_val("tx_drain_byte", {24'h0, uart_din}, 32'h41 + 32'(i));
            tick();
        end
        check_val("tx_empty_valid", {31'h0, uart_din_valid}, 32'h0);
        uart_din_ready = 1'b0;
        cpu_write(A_STATUS, 8'h00);
        cpu_read(32'h8FFF_FFF0);
        check_val("drop_cleared", rdata, 32'h1);
        cpu_read(A_TXDATA);
        check_val("txdata_read_zero", rdata, 32'h0);

        // RX fill with valid held: ready drops after eight bytes.
        uart_dout_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uart_dout = 8'hA0 + 8'(i);
            check_val("rx_fill_ready", {31'h0, uart_dout_ready}, 32'h1);
            tick();
        end
        uart_dout = 8'hA8;
        check_val("rx_full_ready", {31'h0, uart_dout_ready}, 32'h0);
        tick();
        check_val("rx_full_hold", {31'h0, uart_dout_ready}, 32'h0);
        cpu_read(A_COUNT);
        check_val("rx_count_full", rdata, 32'h0000_0800);
        cpu_read(A_RXDATA);
        check_val("rx_pop_first", rdata, 32'hA0);
        check_val("rx_ready_after_pop", {31'h0, uart_dout_ready}, 32'h1);
        tick();
        uart_dout_valid = 1'b0;
        check_val("rx_refull_ready", {31'h0, uart_dout_ready}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(A_RXDATA);
            check_val("rx_drain", rdata, 32'hA0 + 32'(i));
        end
        cpu_read(A_STATUS);
        check_val("rx_drained_status", rdata, 32'h1);

        // Empty RX read returns zero and leaves the count at zero.
        cpu_read(A_RXDATA);
        check_val("rx_empty_read", rdata, 32'h0);
        cpu_read(A_COUNT);
        check_val("rx_empty_count", rdata, 32'h0);

        // Stall freezes CPU-side effects while the UART side keeps running.
        cpu_read(A_STATUS);
        check_val("stall_pre_status", rdata, 32'h1);
        stall           = 1'b1;
        uart_dout_valid = 1'b1;
        uart_dout       = 8'h5A;
        cpu_write(A_TXDATA, 8'h77);
        uart_dout_valid = 1'b0;
        check_val("stall_no_tx_push", {31'h0, uart_din_valid}, 32'h0);
        cpu_read(A_RXDATA);
        stall = 1'b0;
        check_val("stall_rdata_hold", rdata, 32'h1);
        cpu_read(A_COUNT);
        check_val("stall_rx_landed", rdata, 32'h0000_0100);
        cpu_read(A_RXDATA);
        check_val("stall_rx_byte", rdata, 32'h5A);

        // Simultaneous push and pop at count three, across pointer wrap.
        uart_dout_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            uart_dout = 8'h10 + 8'(k);
            tick();
        end
        uart_dout_valid = 1'b0;
        cpu_read(A_COUNT);
        check_val("sim_count_pre", rdata, 32'h0000_0300);
        for (int k = 3; k < 20; k++) begin
            uart_dout_valid = 1'b1;
            uart_dout       = 8'h10 + 8'(k);
            check_val("sim_ready", {31'h0, uart_dout_ready}, 32'h1);
            cpu_read(A_RXDATA);
            check_val("sim_pop_order", rdata, 32'h10 + 32'(k - 3));
        end
        uart_dout_valid = 1'b0;
        cpu_read(A_COUNT);
        check_val("sim_count_post", rdata, 32'h0000_0300);
        for (int k = 17; k < 20; k++) begin
            cpu_read(A_RXDATA);
            check_val("sim_tail", rdata, 32'h10 + 32'(k));
        end

        // Reset mid-operation discards both FIFOs.
        cpu_write(A_TXDATA, 8'hC1);
        cpu_write(A_TXDATA, 8'hC2);
        uart_dout_valid = 1'b1;
        uart_dout       = 8'hD1;
        cpu_read(A_STATUS);
        uart_dout_valid = 1'b0;
        check_val("pre_rst_status", rdata, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("midrst_din_valid", {31'h0, uart_din_valid}, 32'h0);
        check_val("midrst_rdata", rdata, 32'h0);
        cpu_read(A_COUNT);
        check_val("midrst_count", rdata, 32'h0);
        cpu_read(A_STATUS);
        check_val("midrst_status", rdata, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
